// File: rtl/cam_pkg.sv
// Shared types for the CAM access controller: operation codes, response
// status codes and the sequencing FSM states.
package cam_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2
    } cam_op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_FULL    = 2'd1,
        ST_EVICTED = 2'd2
    } cam_status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_EVAL   = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } cam_ctrl_state_e;

    // The reserved encoding 3 behaves as a plain lookup.
    function automatic cam_op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'd1:    decode_op = OP_INSERT;
            2'd2:    decode_op = OP_DELETE;
            default: decode_op = OP_LOOKUP;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after rr_ptr and
// advances the pointer past the winner whenever a grant is issued.
module rr_arbiter
    import cam_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_valid
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] rr_ptr_reg;
    logic [IDW-1:0] rr_ptr_next;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] cand;
    logic           found;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDW'((int'(rr_ptr_reg) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Wrap explicitly so non-power-of-two requester counts stay in range.
    assign rr_ptr_next = (sel == IDW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_reg <= '0;
        end else if (en && found) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    assign grant_idx   = sel;
    assign grant_valid = en && found;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = grant_valid && (sel == IDW'(gi));
        end
    endgenerate

endmodule

// File: rtl/cam_access_ctrl.sv
// Shares one CAM array between several requesters: arbitrates, runs a
// search, optionally writes or invalidates, and returns one tagged response.
module cam_access_ctrl
    import cam_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int CAM_WIDTH     = 32,
    parameter int NUM_CELL      = 16,
    parameter int EVICT_ON_FULL = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*2-1:0]          req_op,
    input  logic [NUM_REQ*CAM_WIDTH-1:0]  req_key,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic                          rsp_hit,
    output logic [$clog2(NUM_CELL)-1:0]   rsp_idx,
    output logic [1:0]                    rsp_status,
    output logic [CAM_WIDTH-1:0]          cam_key,
    output logic                          cam_search_en,
    output logic                          cam_write_en,
    output logic                          cam_inval_en,
    output logic [$clog2(NUM_CELL)-1:0]   cam_idx,
    input  logic                          cam_hit,
    input  logic [$clog2(NUM_CELL)-1:0]   cam_hit_idx,
    input  logic                          cam_full,
    input  logic [$clog2(NUM_CELL)-1:0]   cam_free_idx
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CIW = $clog2(NUM_CELL);

    cam_ctrl_state_e state_reg, state_next;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDW-1:0]     arb_idx;
    logic               arb_valid;
    logic               arb_en;

    cam_op_e            op_reg;
    logic [CAM_WIDTH-1:0] key_reg;
    logic [IDW-1:0]     id_reg;
    logic               hit_reg;
    logic [CIW-1:0]     idx_reg;
    cam_status_e        status_reg;
    logic               inval_reg;
    logic [CIW-1:0]     victim_reg;

    logic               need_write;
    logic               eval_inval;
    logic [CIW-1:0]     eval_idx;
    cam_status_e        eval_status;

    assign arb_en = (state_reg == S_IDLE);

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (req_valid),
        .en         (arb_en),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .grant_valid(arb_valid)
    );

    // Decision taken from the CAM result; only consumed while in EVAL.
    always_comb begin
        need_write  = 1'b0;
        eval_inval  = 1'b0;
        eval_idx    = '0;
        eval_status = ST_OK;
        case (op_reg)
            OP_INSERT: begin
                if (cam_hit) begin
                    eval_idx = cam_hit_idx;
                end else if (!cam_full) begin
                    need_write = 1'b1;
                    eval_idx   = cam_free_idx;
                end else if (EVICT_ON_FULL != 0) begin
                    need_write  = 1'b1;
                    eval_idx    = victim_reg;
                    eval_status = ST_EVICTED;
                end else begin
                    eval_status = ST_FULL;
                end
            end
            OP_DELETE: begin
                if (cam_hit) begin
                    need_write = 1'b1;
                    eval_inval = 1'b1;
                    eval_idx   = cam_hit_idx;
                end
            end
            default: begin
                if (cam_hit) begin
                    eval_idx = cam_hit_idx;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (arb_valid) state_next = S_SEARCH;
            S_SEARCH: state_next = S_EVAL;
            S_EVAL:   state_next = need_write ? S_WRITE : S_RESP;
            S_WRITE:  state_next = S_RESP;
            S_RESP:   if (rsp_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = '0;
        cam_search_en = 1'b0;
        cam_write_en  = 1'b0;
        cam_inval_en  = 1'b0;
        rsp_valid     = 1'b0;
        case (state_reg)
            S_IDLE:   req_ready     = arb_grant;
            S_SEARCH: cam_search_en = 1'b1;
            S_WRITE: begin
                cam_write_en = !inval_reg;
                cam_inval_en = inval_reg;
            end
            S_RESP:   rsp_valid     = 1'b1;
            default: ;
        endcase
    end

    // Capture registers; key stays put from SEARCH through WRITE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_reg     <= OP_LOOKUP;
            key_reg    <= '0;
            id_reg     <= '0;
            hit_reg    <= 1'b0;
            idx_reg    <= '0;
            status_reg <= ST_OK;
            inval_reg  <= 1'b0;
            victim_reg <= '0;
        end else begin
            if (state_reg == S_IDLE && arb_valid) begin
                op_reg  <= decode_op(req_op[arb_idx*2 +: 2]);
                key_reg <= req_key[arb_idx*CAM_WIDTH +: CAM_WIDTH];
                id_reg  <= arb_idx;
            end
            if (state_reg == S_EVAL) begin
                hit_reg    <= cam_hit;
                idx_reg    <= eval_idx;
                status_reg <= eval_status;
                inval_reg  <= eval_inval;
                if (eval_status == ST_EVICTED) begin
                    victim_reg <= victim_reg + 1'b1;
                end
            end
        end
    end

    assign cam_key    = key_reg;
    assign cam_idx    = idx_reg;
    assign rsp_id     = id_reg;
    assign rsp_hit    = hit_reg;
    assign rsp_idx    = idx_reg;
    assign rsp_status = status_reg;

endmodule
